bomb_put_arbiter: RTL and testbench
===================================

Name: bomb_put_arbiter

Overview:
Sits between the player input/movement logic and the bomb tile datapath. It turns raw P1/P2 place-bomb button levels into legal single-cycle put pulses for the bomb datapath and enforces the game rules:
- per-player bomb capacity,
- no bomb on an occupied, exploding or wall tile,
- fair arbitration when both players target the same tile in the same cycle.

It also tracks live bombs per player with its own slot timers, so capacity frees up exactly when each bomb detonates.

Parameters:
- N_SLOTS, 4, max simultaneous bombs per player (slots per player).
- FUSE_CYCLES, 62, cycles from a granted put until that slot is released (put cycle + 61-cycle datapath fuse).
- GRID_W, 16, grid width; grid has GRID_W*GRID_W = 256 tiles, coordinate 8 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- p1_req  in  1  P1 place button level (may be held many cycles)
- p2_req  in  1  P2 place button level
- p1_cor  in  8  P1 current tile index (row*16+col)
- p2_cor  in  8  P2 current tile index
- p1_cap  in  3  P1 allowed bombs, 1..4; 0 treated as 1, >4 treated as 4
- p2_cap  in  3  P2 allowed bombs, same rule
- bomb_un_grid  in  256  1 = unexploded bomb on tile
- explode  in  256  1 = tile currently in explosion
- wall_grid  in  3x256  wall type per tile; 0 = no wall
- p1_put  out  1  one-cycle put pulse to bomb datapath
- p2_put  out  1  one-cycle put pulse
- p1_deny  out  1  one-cycle pulse: P1 request rejected
- p2_deny  out  1  one-cycle pulse: P2 request rejected
- p1_active  out  3  P1 live bomb count, 0..4
- p2_active  out  3  P2 live bomb count, 0..4

Behaviour:
Reset and clocking:
- Reset (synchronous): all outputs 0, all slots free, slot counters 0, edge registers 0, round-robin pointer rr=P1.
- Reset asserted mid-fuse drops all slots immediately; no put is issued in the reset cycle.

Request capture:
- Per-player request FSM with states IDLE, HOLD.
- IDLE -> HOLD on req=1. The request is evaluated in that same cycle (rising-edge event).
- HOLD -> IDLE when req=0.
- A held button produces exactly one evaluation, never a repeat.

Legality check for player p on its edge cycle (all must hold):
- active_p < clamp(cap_p)
- bomb_un_grid[cor_p]=0
- explode[cor_p]=0
- wall_grid[cor_p]=0
- cor_p != tile granted in the previous cycle (by either player). This covers the one-cycle lag before bomb_un_grid updates.

Arbitration:
- Both legal, different tiles: both granted.
- Both legal, same tile: player rr is granted, the other is denied. rr toggles after every such conflict only.

Outputs:
- Grant: put_p=1 and deny_p=0, registered, 1 cycle after the req rising edge.
- Reject: deny_p=1 with the same latency. put and deny are never both 1.
- Put pulses last exactly one cycle.

Slots:
- A grant occupies the lowest-index free slot and loads its counter to 0.
- An occupied slot increments its counter each cycle. It frees when the counter reaches FUSE_CYCLES-1.
- active_p = popcount of occupied slots. It updates the cycle after the put pulse and after a release.
- Same-cycle release and grant for one player: the release is counted first, so a full player whose bomb detonates this cycle may place.

Cap changes:
- A cap change takes effect on the next evaluation.
- Lowering the cap below active never kills live bombs; new puts are denied until active < cap.

Decomposition:
- Package bomb_pkg holds:
  - GRID_W, N_TILES=256, N_SLOTS, FUSE_CYCLES
  - player enum {P1=0, P2=1}
  - EMPTY_WALL=0
  - function clamp_cap
- Sub-module bomb_slot_timer, instantiated once per player.
  - Inputs: clk, reset, grant.
  - Output: active count, 3 bits.
  - Contains the N_SLOTS occupancy bits, the counters, and the lowest-free allocation.
- Top level holds the edge FSMs, the legality checks, the previous-grant register and the rr pointer.

Test Plan:
1. P1 on empty tile 0x21, cap=1, req high for 10 cycles -> one p1_put 1 cycle after the edge; p1_active=1; no second put.
2. P1 cap=2, three separate presses on tiles 0x10, 0x11, 0x12 -> two puts, third gives p1_deny; after FUSE_CYCLES from the first put, p1_active=1 and a new press is granted.
3. Both press on tile 0x55 in the same cycle, after reset -> p1_put only, p2_deny. Repeat the conflict -> p2_put only, p1_deny.
4. P2 presses on a tile with bomb_un_grid=1, then on a tile with wall_grid=2, then on a tile with explode=1 -> three p2_deny pulses, no put, p2_active unchanged.
5. P1 granted on 0x30; P2 presses 0x30 the next cycle while bomb_un_grid[0x30] is still 0 -> p2_deny (previous-grant hazard).
6. Reset asserted while P1 holds 3 live bombs and req is high -> next cycle all outputs 0 and p1_active=0; req still held after reset -> no put until release and re-press.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared types, sizes and helpers for the bomb put arbiter.
// Also holds the capacity clamp and the slot popcount.
package bomb_pkg;

    localparam int GRID_W      = 16;
    localparam int N_TILES     = GRID_W * GRID_W;
    localparam int N_SLOTS     = 4;
    localparam int FUSE_CYCLES = 62;
    localparam logic [2:0] EMPTY_WALL = 3'd0;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } req_state_t;

    // Caps outside 1..N_SLOTS are pulled to the nearest legal value.
    function automatic logic [2:0] clamp_cap(input logic [2:0] cap);
        logic [2:0] res;
        if (cap == 3'd0)
            res = 3'd1;
        else if (cap > 3'(N_SLOTS))
            res = 3'(N_SLOTS);
        else
            res = cap;
        return res;
    endfunction

    function automatic logic [2:0] count_ones(input logic [N_SLOTS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < N_SLOTS; i++)
            n = n + {2'b00, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/bomb_put_arbiter_if.sv
// Bundle of player requests, tile state and put/deny results.
// The arbiter takes the slave side; the player/grid logic drives the master side.
interface bomb_put_arbiter_if;
    import bomb_pkg::*;

    logic                         p1_req;
    logic                         p2_req;
    logic [7:0]                   p1_cor;
    logic [7:0]                   p2_cor;
    logic [2:0]                   p1_cap;
    logic [2:0]                   p2_cap;
    logic [N_TILES-1:0]           bomb_un_grid;
    logic [N_TILES-1:0]           explode;
    logic [N_TILES-1:0][2:0]      wall_grid;
    logic                         p1_put;
    logic                         p2_put;
    logic                         p1_deny;
    logic                         p2_deny;
    logic [2:0]                   p1_active;
    logic [2:0]                   p2_active;

    modport master (
        output p1_req, p2_req, p1_cor, p2_cor, p1_cap, p2_cap,
        output bomb_un_grid, explode, wall_grid,
        input  p1_put, p2_put, p1_deny, p2_deny, p1_active, p2_active
    );

    modport slave (
        input  p1_req, p2_req, p1_cor, p2_cor, p1_cap, p2_cap,
        input  bomb_un_grid, explode, wall_grid,
        output p1_put, p2_put, p1_deny, p2_deny, p1_active, p2_active
    );

endinterface

// File: rtl/bomb_slot_timer.sv
// Per-player bomb slots: occupancy bits, fuse counters and lowest-free allocation.
// 'live' is the occupancy after this cycle's releases, used for the capacity check.
module bomb_slot_timer
    import bomb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       grant,
    output logic [2:0] active,
    output logic [2:0] live
);

    localparam int CNT_W = $clog2(FUSE_CYCLES);

    logic [N_SLOTS-1:0] r_occ;
    logic [CNT_W-1:0]   r_cnt [N_SLOTS];
    logic [2:0]         r_active;
    logic [N_SLOTS-1:0] w_rel;
    logic [N_SLOTS-1:0] w_free;
    logic [N_SLOTS-1:0] w_alloc;
    logic               w_found;

    // A slot releasing this cycle is already free for a same-cycle grant.
    assign w_free = ~r_occ | w_rel;

    always_comb begin
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (w_free[i] && !w_found) begin
                w_alloc[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            assign w_rel[gi] = r_occ[gi] && (r_cnt[gi] == CNT_W'(FUSE_CYCLES - 1));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_occ[gi] <= 1'b0;
                    r_cnt[gi] <= '0;
                end else if (grant && w_alloc[gi]) begin
                    r_occ[gi] <= 1'b1;
                    r_cnt[gi] <= '0;
                end else if (w_rel[gi]) begin
                    r_occ[gi] <= 1'b0;
                    r_cnt[gi] <= '0;
                end else if (r_occ[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            r_active <= 3'd0;
        else
            r_active <= count_ones(r_occ);
    end

    assign active = r_active;
    assign live   = count_ones(r_occ & ~w_rel);

endmodule

// File: rtl/bomb_put_arbiter.sv
// Turns P1/P2 place-button levels into legal one-cycle put pulses for the bomb datapath,
// enforcing capacity, tile occupancy and round-robin fairness on same-tile conflicts.
module bomb_put_arbiter
    import bomb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    bomb_put_arbiter_if.slave    bus
);

    logic [1:0]       w_req;
    logic [1:0][7:0]  w_cor;
    logic [1:0][2:0]  w_cap;
    logic [1:0][2:0]  w_live;
    logic [1:0][2:0]  w_active;
    logic [1:0]       w_edge;
    logic [1:0]       w_legal;
    logic [1:0]       w_grant;
    logic             w_conflict;

    req_state_t       r_state [2];
    player_t          r_rr;
    logic [1:0]       r_prev_v;
    logic [1:0][7:0]  r_prev_tile;
    logic [1:0]       r_put;
    logic [1:0]       r_deny;

    assign w_req = {bus.p2_req, bus.p1_req};
    assign w_cor = {bus.p2_cor, bus.p1_cor};
    assign w_cap = {bus.p2_cap, bus.p1_cap};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            assign w_edge[gi] = (r_state[gi] == S_IDLE) && w_req[gi];

            // Previous-cycle grants block the tile until bomb_un_grid catches up.
            assign w_legal[gi] = w_edge[gi]
                && (w_live[gi] < clamp_cap(w_cap[gi]))
                && !bus.bomb_un_grid[w_cor[gi]]
                && !bus.explode[w_cor[gi]]
                && (bus.wall_grid[w_cor[gi]] == EMPTY_WALL)
                && !(r_prev_v[0] && (r_prev_tile[0] == w_cor[gi]))
                && !(r_prev_v[1] && (r_prev_tile[1] == w_cor[gi]));

            bomb_slot_timer u_slot_timer (
                .clk    (clk),
                .reset  (reset),
                .grant  (w_grant[gi]),
                .active (w_active[gi]),
                .live   (w_live[gi])
            );
        end
    endgenerate

    always_comb begin
        w_conflict = (&w_legal) && (w_cor[0] == w_cor[1]);
        w_grant    = w_legal;
        if (w_conflict)
            w_grant = (r_rr == P1) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // A button held through reset counts as already seen: it must be re-pressed.
            for (int i = 0; i < 2; i++)
                r_state[i] <= w_req[i] ? S_HOLD : S_IDLE;
            r_rr        <= P1;
            r_prev_v    <= '0;
            r_prev_tile <= '0;
            r_put       <= '0;
            r_deny      <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (r_state[i])
                    S_IDLE:  if (w_req[i])  r_state[i] <= S_HOLD;
                    S_HOLD:  if (!w_req[i]) r_state[i] <= S_IDLE;
                    default: r_state[i] <= S_IDLE;
                endcase
            end
            r_put       <= w_grant;
            r_deny      <= w_edge & ~w_grant;
            r_prev_v    <= w_grant;
            r_prev_tile <= w_cor;
            if (w_conflict)
                r_rr <= (r_rr == P1) ? P2 : P1;
        end
    end

    assign bus.p1_put    = r_put[0];
    assign bus.p2_put    = r_put[1];
    assign bus.p1_deny   = r_deny[0];
    assign bus.p2_deny   = r_deny[1];
    assign bus.p1_active = w_active[0];
    assign bus.p2_active = w_active[1];

endmodule

// File: tb/tb_bomb_put_arbiter.sv
// Directed scoreboard bench: stimulus queues expected pulse vectors, a negedge monitor pops and compares.
module tb_bomb_put_arbiter;
    import bomb_pkg::*;

    localparam logic [3:0] P1PUT = 4'b1000;
    localparam logic [3:0] P1DEN = 4'b0100;
    localparam logic [3:0] P2PUT = 4'b0010;
    localparam logic [3:0] P2DEN = 4'b0001;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [3:0] exp_q [$];
    logic [3:0] mon_obs;
    logic [3:0] mon_exp;

    bomb_put_arbiter_if bus ();

    bomb_put_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            mon_obs = {bus.p1_put, bus.p1_deny, bus.p2_put, bus.p2_deny};
            if (mon_obs != 4'b0000) begin
                $display("txn t=%0t p1_put=%b p1_deny=%b p2_put=%b p2_deny=%b p1_active=%0d p2_active=%0d",
                         $time, mon_obs[3], mon_obs[2], mon_obs[1], mon_obs[0], bus.p1_active, bus.p2_active);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse got=%b want=none", mon_obs);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_obs !== mon_exp) begin
                        bad++;
                        $display("FAIL pulse_vector got=%b want=%b", mon_obs, mon_exp);
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // One press: edge on the next clock, button released one cycle later.
    task automatic press(input int p, input logic [7:0] cor, input logic [3:0] expv);
        if (p == 0) begin
            bus.p1_cor = cor;
            bus.p1_req = 1'b1;
        end else begin
            bus.p2_cor = cor;
            bus.p2_req = 1'b1;
        end
        exp_q.push_back(expv);
        tick(1);
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        tick(1);
    endtask

    task automatic press_both(input logic [7:0] c1, input logic [7:0] c2, input logic [3:0] expv);
        bus.p1_cor = c1;
        bus.p2_cor = c2;
        bus.p1_req = 1'b1;
        bus.p2_req = 1'b1;
        exp_q.push_back(expv);
        tick(1);
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        tick(1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.p1_req = 1'b0;
        bus.p2_req = 1'b0;
        bus.p1_cor = 8'h00;
        bus.p2_cor = 8'h00;
        bus.p1_cap = 3'd4;
        bus.p2_cap = 3'd4;
        bus.bomb_un_grid = '0;
        bus.explode      = '0;
        bus.wall_grid    = '0;

        // Reset state
        do_reset();
        chk("rst_p1_put",    int'(bus.p1_put),    0);
        chk("rst_p2_put",    int'(bus.p2_put),    0);
        chk("rst_p1_deny",   int'(bus.p1_deny),   0);
        chk("rst_p2_deny",   int'(bus.p2_deny),   0);
        chk("rst_p1_active", int'(bus.p1_active), 0);
        chk("rst_p2_active", int'(bus.p2_active), 0);

        // 1: held button gives one put only
        bus.p1_cap = 3'd1;
        bus.p1_cor = 8'h21;
        bus.p1_req = 1'b1;
        exp_q.push_back(P1PUT);
        tick(10);
        bus.p1_req = 1'b0;
        tick(1);
        chk("t1_p1_active", int'(bus.p1_active), 1);

        // 2: capacity 2, third denied, release counted before same-cycle grant
        do_reset();
        bus.p1_cap = 3'd2;
        press(0, 8'h10, P1PUT);
        press(0, 8'h11, P1PUT);
        press(0, 8'h12, P1DEN);
        chk("t2_full_active", int'(bus.p1_active), 2);
        tick(54);
        press(0, 8'h13, P1DEN);
        chk("t2_pre_release_active", int'(bus.p1_active), 2);
        press(0, 8'h14, P1PUT);
        chk("t2_swap_active", int'(bus.p1_active), 2);
        tick(2);
        chk("t2_after_release_active", int'(bus.p1_active), 1);

        // 3: same-tile conflict alternates fairly
        do_reset();
        bus.p1_cap = 3'd4;
        bus.p2_cap = 3'd4;
        press_both(8'h55, 8'h55, P1PUT | P2DEN);
        tick(1);
        press_both(8'h55, 8'h55, P2PUT | P1DEN);
        tick(1);
        press_both(8'h56, 8'h57, P1PUT | P2PUT);
        tick(1);
        chk("t3_p1_active", int'(bus.p1_active), 2);
        chk("t3_p2_active", int'(bus.p2_active), 2);

        // 4: occupied / wall / exploding tiles, and cap clamping
        do_reset();
        bus.p2_cap = 3'd7;
        bus.bomb_un_grid[8'h40] = 1'b1;
        bus.wall_grid[8'h41]    = 3'd2;
        bus.explode[8'h42]      = 1'b1;
        press(1, 8'h40, P2DEN);
        press(1, 8'h41, P2DEN);
        press(1, 8'h42, P2DEN);
        chk("t4_p2_active_blocked", int'(bus.p2_active), 0);
        press(1, 8'h43, P2PUT);
        bus.p1_cap = 3'd0;
        press(0, 8'h01, P1PUT);
        press(0, 8'h02, P1DEN);
        chk("t4_p1_active_cap0", int'(bus.p1_active), 1);
        chk("t4_p2_active", int'(bus.p2_active), 1);
        bus.bomb_un_grid = '0;
        bus.wall_grid    = '0;
        bus.explode      = '0;

        // 5: previous-cycle grant hazard
        do_reset();
        bus.p1_cap = 3'd4;
        bus.p2_cap = 3'd4;
        bus.p1_cor = 8'h30;
        bus.p1_req = 1'b1;
        exp_q.push_back(P1PUT);
        tick(1);
        bus.p1_req = 1'b0;
        bus.p2_cor = 8'h30;
        bus.p2_req = 1'b1;
        exp_q.push_back(P2DEN);
        tick(1);
        bus.p2_req = 1'b0;
        tick(2);
        chk("t5_p2_active", int'(bus.p2_active), 0);

        // 6: reset mid-fuse with button held
        do_reset();
        press(0, 8'h70, P1PUT);
        press(0, 8'h71, P1PUT);
        press(0, 8'h72, P1PUT);
        chk("t6_p1_active_before", int'(bus.p1_active), 3);
        bus.p1_cor = 8'h73;
        bus.p1_req = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("t6_p1_put_after_rst",  int'(bus.p1_put),    0);
        chk("t6_p1_deny_after_rst", int'(bus.p1_deny),   0);
        chk("t6_p1_active_after",   int'(bus.p1_active), 0);
        tick(3);
        bus.p1_req = 1'b0;
        tick(1);
        press(0, 8'h73, P1PUT);
        chk("t6_p1_active_repress", int'(bus.p1_active), 1);

        tick(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
